// File: rtl/ccu_pkg.sv
// Shared types and helpers for the multi-crossing crosswalk control unit.
package ccu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        ORANGE = 2'd2,
        CLEAR  = 2'd3
    } ccu_state_t;

    // Timer width: $clog2 of the longest phase duration, at least 1 bit.
    function automatic int unsigned ccu_timer_width(
        input int unsigned tvalue,
        input int unsigned green_mult,
        input int unsigned orange_mult,
        input int unsigned clear_mult
    );
        int unsigned longest;
        int unsigned w;
        longest = tvalue * green_mult;
        if (tvalue * orange_mult > longest) longest = tvalue * orange_mult;
        if (tvalue * clear_mult > longest) longest = tvalue * clear_mult;
        w = $clog2(longest);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ccu_phase_timer.sv
// Loadable phase down-counter; holds at zero once the terminal count is reached.
module ccu_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_q;

    // Load on phase entry, otherwise count down towards zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/ccu_multi.sv
// Multi-crossing crosswalk control unit: latches walk requests, grants crossings
// round-robin and sequences GREEN -> ORANGE -> CLEAR for the granted crossing.
// Optional feature macro: CCU_COUNTDOWN_EN adds the 'remaining' countdown output.
module ccu_multi
    import ccu_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned TVALUE      = 4,
    parameter int unsigned GREEN_MULT  = 3,
    parameter int unsigned ORANGE_MULT = 1,
    parameter int unsigned CLEAR_MULT  = 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NCH-1:0]                             req,
    output logic [NCH-1:0]                             green_walk,
    output logic [NCH-1:0]                             orange_walk,
    output logic [NCH-1:0]                             red_hand,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]   active_ch,
    output logic [NCH-1:0]                             pending,
    output logic                                       busy
`ifdef CCU_COUNTDOWN_EN
    ,
    output logic [ccu_timer_width(TVALUE, GREEN_MULT, ORANGE_MULT, CLEAR_MULT)-1:0] remaining
`endif
);

    localparam int unsigned AW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TW = ccu_timer_width(TVALUE, GREEN_MULT, ORANGE_MULT, CLEAR_MULT);

    localparam logic [TW-1:0] GREEN_LOAD  = TW'(TVALUE * GREEN_MULT - 1);
    localparam logic [TW-1:0] ORANGE_LOAD = TW'(TVALUE * ORANGE_MULT - 1);
    localparam logic [TW-1:0] CLEAR_LOAD  = TW'(TVALUE * CLEAR_MULT - 1);

    ccu_state_t     state_q, state_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic [AW-1:0]  active_q, last_q;
    logic [AW-1:0]  grant_idx;
    logic           grant;
    logic           timer_load;
    logic [TW-1:0]  timer_load_value;
    logic [TW-1:0]  timer_count;
    logic           timer_done;

    ccu_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .load_value(timer_load_value),
        .count     (timer_count),
        .done      (timer_done)
    );

    // Round-robin search starting one past the last granted crossing.
    always_comb begin
        logic found;
        int unsigned idx;
        found     = 1'b0;
        grant_idx = last_q;
        for (int unsigned off = 1; off <= NCH; off++) begin
            idx = (int'(last_q) + off) % NCH;
            if (!found && pending_q[idx]) begin
                found     = 1'b1;
                grant_idx = AW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a grant also loads the GREEN duration into the timer.
    always_comb begin
        state_d          = state_q;
        grant            = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = '0;
        unique case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    state_d          = GREEN;
                    grant            = 1'b1;
                    timer_load       = 1'b1;
                    timer_load_value = GREEN_LOAD;
                end
            end
            GREEN: begin
                if (timer_done) begin
                    state_d          = ORANGE;
                    timer_load       = 1'b1;
                    timer_load_value = ORANGE_LOAD;
                end
            end
            ORANGE: begin
                if (timer_done) begin
                    state_d          = CLEAR;
                    timer_load       = 1'b1;
                    timer_load_value = CLEAR_LOAD;
                end
            end
            CLEAR: begin
                if (timer_done) begin
                    if (pending_q != '0) begin
                        state_d          = GREEN;
                        grant            = 1'b1;
                        timer_load       = 1'b1;
                        timer_load_value = GREEN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latching: the walking crossing ignores its own request, and the
    // clear on grant wins over a simultaneous set.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (req[i] && !(((state_q == GREEN) || (state_q == ORANGE)) &&
                            (active_q == AW'(i)))) begin
                pending_d[i] = 1'b1;
            end
        end
        if (grant) begin
            pending_d[grant_idx] = 1'b0;
        end
    end

    // Request, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            active_q  <= '0;
            last_q    <= AW'(NCH - 1);
        end else begin
            pending_q <= pending_d;
            if (grant) begin
                active_q <= grant_idx;
                last_q   <= grant_idx;
            end
        end
    end

    // Output decode from registered state and granted crossing.
    always_comb begin
        green_walk  = '0;
        orange_walk = '0;
        red_hand    = '1;
        if (state_q == GREEN) begin
            green_walk[active_q] = 1'b1;
            red_hand[active_q]   = 1'b0;
        end else if (state_q == ORANGE) begin
            orange_walk[active_q] = 1'b1;
            red_hand[active_q]    = 1'b0;
        end
    end

    assign active_ch = active_q;
    assign pending   = pending_q;
    assign busy      = (state_q != IDLE);

`ifdef CCU_COUNTDOWN_EN
    assign remaining = (state_q == IDLE) ? '0 : timer_count;
`else
    logic unused_count;
    assign unused_count = ^timer_count;
`endif

endmodule

// File: tb/tb_ccu_multi.sv
// Scoreboard bench for ccu_multi: a behavioural model pushes the expected
// post-edge outputs when stimulus is driven; they are popped and compared
// just after the edge. Build with CCU_COUNTDOWN_EN to also check 'remaining'.
module tb_ccu_multi;

    localparam int NCH = 4;
    localparam int TVALUE = 4;
    localparam int GM = 3;
    localparam int OM = 1;
    localparam int CM = 1;
    localparam int TW = 4;

    typedef struct {
        logic [3:0] g;
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] p;
        logic [1:0] a;
        logic       b;
        logic [3:0] rem;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] green_walk, orange_walk, red_hand, pending;
    logic [1:0] active_ch;
    logic       busy;
`ifdef CCU_COUNTDOWN_EN
    logic [TW-1:0] remaining;
`endif

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];

    // Model state: 0 idle, 1 green, 2 orange, 3 clear; elapsed counts up.
    int m_state = 0;
    int m_elapsed = 0;
    logic [3:0] m_pending = '0;
    int m_last = NCH - 1;
    int m_active = 0;

    always #5 clk = ~clk;

    ccu_multi #(
        .NCH        (NCH),
        .TVALUE     (TVALUE),
        .GREEN_MULT (GM),
        .ORANGE_MULT(OM),
        .CLEAR_MULT (CM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .green_walk (green_walk),
        .orange_walk(orange_walk),
        .red_hand   (red_hand),
        .active_ch  (active_ch),
        .pending    (pending),
        .busy       (busy)
`ifdef CCU_COUNTDOWN_EN
        ,
        .remaining  (remaining)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int dur(input int s);
        case (s)
            1:       return TVALUE * GM;
            2:       return TVALUE * OM;
            3:       return TVALUE * CM;
            default: return 1;
        endcase
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rst);
        int g;
        bit found;
        logic [3:0] np;
        if (rst) begin
            m_state = 0; m_elapsed = 0; m_pending = '0; m_last = NCH - 1; m_active = 0;
            return;
        end
        g = m_last;
        found = 0;
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_last + k) % NCH;
            if (!found && m_pending[c]) begin
                g = c;
                found = 1;
            end
        end
        np = m_pending | r;
        if (m_state == 1 || m_state == 2) np[m_active] = m_pending[m_active];
        if (m_state == 0) begin
            if (m_pending != 0) begin
                m_state = 1; m_elapsed = 0; m_active = g; m_last = g; np[g] = 1'b0;
            end
        end else if (m_elapsed == dur(m_state) - 1) begin
            m_elapsed = 0;
            if (m_state == 3) begin
                if (m_pending != 0) begin
                    m_state = 1; m_active = g; m_last = g; np[g] = 1'b0;
                end else begin
                    m_state = 0;
                end
            end else begin
                m_state = m_state + 1;
            end
        end else begin
            m_elapsed++;
        end
        m_pending = np;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g = '0; e.o = '0; e.r = 4'hf;
        if (m_state == 1) begin e.g[m_active] = 1'b1; e.r[m_active] = 1'b0; end
        if (m_state == 2) begin e.o[m_active] = 1'b1; e.r[m_active] = 1'b0; end
        e.p = m_pending;
        e.a = 2'(m_active);
        e.b = (m_state != 0);
        e.rem = (m_state == 0) ? 4'd0 : 4'(dur(m_state) - 1 - m_elapsed);
        return e;
    endfunction

    // Drive one cycle of stimulus, then compare the popped expectation after the edge.
    task automatic cycle(input logic [3:0] r, input logic rst);
        exp_t e;
        req = r;
        reset = rst;
        model_step(r, rst);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("green_walk", 32'(green_walk), 32'(e.g));
        check_eq("orange_walk", 32'(orange_walk), 32'(e.o));
        check_eq("red_hand", 32'(red_hand), 32'(e.r));
        check_eq("pending", 32'(pending), 32'(e.p));
        check_eq("busy", 32'(busy), 32'(e.b));
        if (e.b) check_eq("active_ch", 32'(active_ch), 32'(e.a));
`ifdef CCU_COUNTDOWN_EN
        check_eq("remaining", 32'(remaining), 32'(e.rem));
`endif
    endtask

    task automatic run_until(input int target, input logic [3:0] r, input int limit);
        int n;
        n = 0;
        while (m_state != target && n < limit) begin
            cycle(r, 1'b0);
            n++;
        end
        if (m_state != target) check_eq("wait_bound", 32'(m_state), 32'(target));
    endtask

    initial begin
        // 1: reset held three cycles.
        repeat (3) cycle(4'b0000, 1'b1);
        check_eq("rst_red", 32'(red_hand), 32'hf);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_active", 32'(active_ch), 32'h0);

        // 2: single request on crossing 2.
        cycle(4'b0100, 1'b0);
        check_eq("t2_pending", 32'(pending), 32'h4);
        check_eq("t2_not_yet", 32'(green_walk), 32'h0);
        cycle(4'b0000, 1'b0);
        check_eq("t2_green", 32'(green_walk), 32'h4);
        repeat (30) cycle(4'b0000, 1'b0);
        check_eq("t2_idle", 32'(busy), 32'h0);

        // 3: three simultaneous requests served 0, 1, 3 back-to-back.
        cycle(4'b0000, 1'b1);
        cycle(4'b1011, 1'b0);
        check_eq("t3_pending0", 32'(pending), 32'hb);
        cycle(4'b0000, 1'b0);
        check_eq("t3_first", 32'(green_walk), 32'h1);
        check_eq("t3_pending1", 32'(pending), 32'ha);
        repeat (20) cycle(4'b0000, 1'b0);
        check_eq("t3_second", 32'(green_walk), 32'h2);
        repeat (20) cycle(4'b0000, 1'b0);
        check_eq("t3_third", 32'(green_walk), 32'h8);
        check_eq("t3_pending3", 32'(pending), 32'h0);
        repeat (25) cycle(4'b0000, 1'b0);

        // 4: own request ignored in GREEN, honoured in CLEAR.
        cycle(4'b0000, 1'b1);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        repeat (3) cycle(4'b0010, 1'b0);
        check_eq("t4_ignored", 32'(pending), 32'h0);
        run_until(3, 4'b0000, 40);
        cycle(4'b0010, 1'b0);
        check_eq("t4_latched", 32'(pending), 32'h2);
        run_until(1, 4'b0000, 10);
        check_eq("t4_regrant", 32'(green_walk), 32'h2);
        repeat (25) cycle(4'b0000, 1'b0);

        // 5: reset in the middle of ORANGE discards the pending request.
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b0);
        run_until(2, 4'b0000, 40);
        cycle(4'b0001, 1'b0);
        check_eq("t5_pend", 32'(pending), 32'h1);
        cycle(4'b0000, 1'b1);
        check_eq("t5_red", 32'(red_hand), 32'hf);
        check_eq("t5_pending", 32'(pending), 32'h0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        check_eq("t5_grant0", 32'(green_walk), 32'h1);
        repeat (25) cycle(4'b0000, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            cycle(r, ($urandom_range(0, 99) == 0));
        end
        repeat (30) cycle(4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccu_multi.md
Name: ccu_multi

Overview:
Next-generation crosswalk control unit serving NCH pedestrian crossings from one controller.
- Latches per-crossing walk requests and grants them round-robin, one crossing at a time.
- Each grant runs GREEN, then ORANGE, then an all-red CLEAR interval.
- Phase timing comes from an internal base-tick counter times per-phase multipliers; it replaces the single-crossing fixed-multiplier ccu/counter pair.

Parameters:
- NCH, 4, number of crossings (>=1).
- TVALUE, 4, clock cycles per base time unit (>=1).
- GREEN_MULT, 3, base units in GREEN (>=1).
- ORANGE_MULT, 1, base units in ORANGE (>=1).
- CLEAR_MULT, 1, base units in all-red CLEAR (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- req  in  NCH  walk request per crossing; level, sampled every clk edge
- green_walk  out  NCH  walk signal per crossing
- orange_walk  out  NCH  finish-crossing signal per crossing
- red_hand  out  NCH  don't-walk signal per crossing
- active_ch  out  max(1,$clog2(NCH))  crossing currently granted, or last granted
- pending  out  NCH  latched, not-yet-served requests
- busy  out  1  high in GREEN, ORANGE or CLEAR

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state IDLE, all timers 0
  - red_hand all ones; green_walk and orange_walk 0
  - pending 0, active_ch 0, busy 0
  - round-robin pointer last = NCH-1, so crossing 0 has first priority
- Reset mid-phase: all of the above takes effect at the next edge; pending requests are discarded.
- Request latching:
  - pending[i] is set at the edge where req[i]=1.
  - Exception: req[i] is ignored while crossing i is in GREEN or ORANGE.
  - pending[i] clears at the edge where crossing i enters GREEN; the clear wins over a simultaneous set.
- Arbitration: select the first i with pending[i]=1, searching from last+1 upward with wrap modulo NCH. On grant: active_ch<=i, last<=i.
- FSM states: IDLE, GREEN, ORANGE, CLEAR.
  - IDLE -> GREEN at the first edge where pending != 0.
  - GREEN -> ORANGE after exactly TVALUE*GREEN_MULT cycles.
  - ORANGE -> CLEAR after exactly TVALUE*ORANGE_MULT cycles.
  - CLEAR -> GREEN (next arbitrated crossing) if pending != 0 at the terminal cycle; otherwise CLEAR -> IDLE. There is no extra IDLE cycle between back-to-back grants.
- Timing: phase down-counter loads duration-1 on phase entry and decrements each cycle; terminal count is 0.
- Latency: req[i] high at edge k from IDLE gives pending[i]=1 after k, and green_walk[i]=1 after edge k+1.
- Outputs, decoded from registered state and active_ch:
  - exactly one of {green_walk[i], orange_walk[i], red_hand[i]} is 1 for every i, every cycle
  - in GREEN/ORANGE, only channel active_ch is non-red
  - in IDLE and CLEAR, all channels are red
- NCH=1: active_ch is constantly 0; a request made during the crossing's own GREEN/ORANGE is ignored, but one made during its CLEAR re-grants it directly.
- Width rule: the timer width is $clog2 of the largest phase duration, minimum 1.

Optional Feature:
- Macro: CCU_COUNTDOWN_EN.
- When defined: adds output remaining [TW-1:0], equal to the phase down-counter value in GREEN/ORANGE/CLEAR and 0 in IDLE. It is 0 on reset and drives a pedestrian countdown display.
- When undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package ccu_pkg holds:
  - state enum ccu_state_t (IDLE, GREEN, ORANGE, CLEAR)
  - localparam function computing timer width from TVALUE and the multipliers
- Sub-module ccu_phase_timer: loadable down-counter with load value, load strobe, and done output (count==0).
- The FSM, request latching and round-robin arbiter stay in ccu_multi.

Test Plan (NCH=4, TVALUE=4, GREEN_MULT=3, ORANGE_MULT=1, CLEAR_MULT=1):
1. Reset held 3 cycles, no req -> red_hand=4'b1111, green_walk=0, busy=0, pending=0 throughout.
2. Single req[2] pulse at edge k -> pending=4'b0100 after k; green_walk=4'b0100 for 12 cycles from k+1; orange_walk=4'b0100 for 4 cycles; all red for 4 cycles; then IDLE, busy=0.
3. req=4'b1011 held 1 cycle from reset -> grants in order 0,1,3, back-to-back, each 20 cycles; pending goes 1011 -> 1010 -> 1000 -> 0000.
4. req[1] raised during crossing 1's GREEN and during its CLEAR -> the GREEN request is ignored; the CLEAR request re-grants crossing 1 directly after CLEAR.
5. Reset asserted mid-ORANGE with pending=4'b0001 -> next cycle all red, pending=0, busy=0; next grant goes to crossing 0.
6. With CCU_COUNTDOWN_EN, single req[0] -> remaining counts 11..0 in GREEN, 3..0 in ORANGE, 3..0 in CLEAR, 0 in IDLE.
